// File: rtl/five_cmd_gen.sv
// Command stage in front of the 4-state status FSM: synchronizes and debounces the
// start/stop/toggle buttons, turns each debounced press into a one-cycle command code
// on sig, and otherwise drives the idle code of the state the FSM is expected to be in.
module five_cmd_gen #(
    parameter int unsigned DEB_CYCLES = 4,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_start,
    input  logic       btn_stop,
    input  logic       btn_toggle,
    input  logic [1:0] status,
    output logic [1:0] sig,
    output logic       cmd_valid,
    output logic       rejected
);

    // Button index: 0 start, 1 stop, 2 toggle
    localparam int unsigned NumBtn = 3;

    localparam logic [CNT_W-1:0] DebLimit = CNT_W'(DEB_CYCLES);
    localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StCounting = 2'd1;
    localparam logic [1:0] StPaused   = 2'd2;
    localparam logic [1:0] StRunning  = 2'd3;

    localparam logic [1:0] SigStart  = 2'b00;
    localparam logic [1:0] SigStop   = 2'b01;
    localparam logic [1:0] SigPause  = 2'b10;
    localparam logic [1:0] SigResume = 2'b11;

    logic [NumBtn-1:0] btn_raw;
    logic [NumBtn-1:0] sync1_q, sync2_q;
    logic [NumBtn-1:0] lvl_q, lvl_d, lvl_prev_q;
    logic [CNT_W-1:0]  cnt_q [NumBtn];
    logic [CNT_W-1:0]  cnt_d [NumBtn];
    logic [NumBtn-1:0] press;

    logic [1:0] sig_q, sig_d;
    logic       cmd_valid_q, cmd_valid_d;
    logic       rejected_q, rejected_d;
    logic [1:0] target_q, target_d;

    logic [1:0] exp_state;
    logic       legal;
    logic       losers;
    logic [1:0] cmd_code;
    logic [1:0] cmd_target;

    assign btn_raw = {btn_toggle, btn_stop, btn_start};

    // A press is the first cycle the debounced level is seen high.
    assign press = lvl_q & ~lvl_prev_q;

    function automatic logic [1:0] idle_code(input logic [1:0] st);
        logic [1:0] code;
        code = SigStop;
        if (st == StPaused)  code = SigPause;
        if (st == StRunning) code = SigResume;
        return code;
    endfunction

    // Synchronizer, debounce counters and debounced levels.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            lvl_q      <= '0;
            lvl_prev_q <= '0;
            cnt_q      <= '{default: '0};
        end else begin
            sync1_q    <= btn_raw;
            sync2_q    <= sync1_q;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
            cnt_q      <= cnt_d;
        end
    end

    // Debounce: count consecutive samples that disagree with the level; flip on the limit.
    always_comb begin
        lvl_d = lvl_q;
        for (int i = 0; i < NumBtn; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != lvl_q[i]) begin
                if (cnt_q[i] + CntOne >= DebLimit) begin
                    lvl_d[i] = ~lvl_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
    end

    // Resolve the winning press (stop > start > toggle) and its legality in this status.
    always_comb begin
        legal      = 1'b0;
        losers     = 1'b0;
        cmd_code   = SigStop;
        cmd_target = StIdle;
        if (press[1]) begin
            legal      = (status == StPaused) || (status == StRunning);
            cmd_code   = SigStop;
            cmd_target = StIdle;
            losers     = press[0] | press[2];
        end else if (press[0]) begin
            legal      = (status == StIdle);
            cmd_code   = SigStart;
            cmd_target = StCounting;
            losers     = press[2];
        end else if (press[2]) begin
            if (status == StRunning) begin
                legal      = 1'b1;
                cmd_code   = SigPause;
                cmd_target = StPaused;
            end else if (status == StPaused) begin
                legal      = 1'b1;
                cmd_code   = SigResume;
                cmd_target = StRunning;
            end
        end
    end

    // Next command/idle code; the cycle after a command idles on that command's target
    // because the FSM's status has not caught up yet.
    always_comb begin
        exp_state   = cmd_valid_q ? target_q : status;
        sig_d       = idle_code(exp_state);
        cmd_valid_d = 1'b0;
        rejected_d  = 1'b0;
        target_d    = target_q;
        if (|press) begin
            if (cmd_valid_q) begin
                // Lockout cycle: every press is dropped.
                rejected_d = 1'b1;
            end else begin
                if (legal) begin
                    cmd_valid_d = 1'b1;
                    sig_d       = cmd_code;
                    target_d    = cmd_target;
                end
                if (!legal || losers) begin
                    rejected_d = 1'b1;
                end
            end
        end
    end

    // Registered outputs; cmd_valid_q doubles as the one-cycle lockout flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sig_q       <= SigStop;
            cmd_valid_q <= 1'b0;
            rejected_q  <= 1'b0;
            target_q    <= StIdle;
        end else begin
            sig_q       <= sig_d;
            cmd_valid_q <= cmd_valid_d;
            rejected_q  <= rejected_d;
            target_q    <= target_d;
        end
    end

    assign sig       = sig_q;
    assign cmd_valid = cmd_valid_q;
    assign rejected  = rejected_q;

endmodule
